// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative RV32M multiply/divide unit
//
// Multi-cycle companion to the execute-stage ALU. One operation is accepted
// per start pulse. Multiplies use a radix-2 shift-add over a 2*XLEN-bit
// accumulator. Divides use a restoring algorithm that trial-subtracts into
// an XLEN+1-bit value. Signed operands are reduced to magnitudes when the
// operation is accepted, and the sign is corrected in the final FIX cycle.
//
// Parameters
//   XLEN    operand/result width (even, >= 8)
//   TAGW    width of the pass-through destination tag
//
// Ports
//   clk       rising-edge clock
//   Rst       synchronous active-high reset (wins over flush and start)
//   start     request, sampled only while idle
//   flush     abort any operation in flight (wins over start)
//   op        funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b      rs1 / rs2 operands
//   in_tag    destination tag, captured with start
//   busy      high from the accepting edge until the edge that raises done
//   done      one-cycle result-valid pulse
//   res       result, held until the next completed operation
//   out_tag   tag of the completed operation, held after done
//
// Build option
//   MDU_EARLY_OUT_EN  When this macro is defined, three cases skip the
//                     iterations and go from IDLE straight to FIX:
//                       - divide by zero
//                       - signed overflow
//                       - a multiply with a zero operand
//                     These cases return in 2 edges. Without the macro,
//                     every operation takes XLEN+2 edges.
// -----------------------------------------------------------------------------
module mdu_iter #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [TAGW-1:0] in_tag,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res,
    output logic [TAGW-1:0] out_tag
);

    localparam int CNTW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,   state_d;
    logic [CNTW-1:0]     cnt_q,     cnt_d;
    logic [2:0]          op_q,      op_d;
    logic [TAGW-1:0]     tag_q,     tag_d;
    logic                neg_q,     neg_d;      // product / quotient sign
    logic                rneg_q,    rneg_d;     // remainder sign (sign of a)
    logic                dz_q,      dz_d;       // divide by zero
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   low half holds the dividend, which shifts out while
    //           quotient bits shift in.
    logic [2*XLEN-1:0]   acc_q,     acc_d;
    logic [XLEN-1:0]     opb_q,     opb_d;      // multiplicand / divisor magnitude
    logic [XLEN-1:0]     rem_q,     rem_d;      // partial remainder
    logic                done_q,    done_d;
    logic [XLEN-1:0]     res_q,     res_d;
    logic [TAGW-1:0]     out_tag_q, out_tag_d;

    // ------------------------------------------------------------------
    // Operand conditioning at capture time
    // ------------------------------------------------------------------
    logic            a_sgn, b_sgn;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_div_in;
    logic            div_zero_in;

    always_comb begin
        // MUL is signed*signed. Its low half would be the same either way.
        a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV) || (op == OP_REM);
        b_sgn = (op == OP_MUL) || (op == OP_MULH) ||
                (op == OP_DIV) || (op == OP_REM);
        neg_a = a_sgn & a[XLEN-1];
        neg_b = b_sgn & b[XLEN-1];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
        is_div_in   = op[2];
        div_zero_in = is_div_in & (b == '0);
    end

`ifdef MDU_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic              ovf_in;
    logic              mul_zero_in;
    logic              early_in;
    logic [2*XLEN-1:0] early_acc;
    logic [XLEN-1:0]   early_rem;

    // Preload acc and rem with the final magnitudes. FIX then applies
    // exactly the same sign correction as it does after a full run.
    always_comb begin
        ovf_in      = ((op == OP_DIV) || (op == OP_REM)) &&
                      (a == MIN_NEG) && (b == '1);
        mul_zero_in = ~op[2] & ((a == '0) || (b == '0));
        early_in    = div_zero_in | ovf_in | mul_zero_in;
        early_acc   = '0;
        early_rem   = '0;
        if (div_zero_in) begin
            early_acc = {{XLEN{1'b0}}, {XLEN{1'b1}}};
            early_rem = mag_a;
        end else if (ovf_in) begin
            early_acc = {{XLEN{1'b0}}, MIN_NEG};
        end
    end
`endif

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_trial;
    logic            div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opb_q};
        // The top bit of the XLEN+1-bit trial acts as the borrow.
        div_ge    = ~div_trial[XLEN];
    end

    // ------------------------------------------------------------------
    // Final sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_sel;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        // Division by zero must return all ones whatever the operand signs.
        quo_fix  = (neg_q & ~dz_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = rneg_q ? -rem_q : rem_q;
        unique case (op_q)
            OP_MUL:                        res_sel = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res_sel = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               res_sel = quo_fix;
            default:                       res_sel = rem_fix;   // REM, REMU
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        tag_d     = tag_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        res_d     = res_q;
        out_tag_d = out_tag_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    op_d    = op;
                    tag_d   = in_tag;
                    neg_d   = neg_a ^ neg_b;
                    rneg_d  = neg_a;
                    dz_d    = div_zero_in;
                    rem_d   = '0;
                    if (is_div_in) begin
                        acc_d = {{XLEN{1'b0}}, mag_a};
                        opb_d = mag_b;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, mag_b};
                        opb_d = mag_a;
                    end
`ifdef MDU_EARLY_OUT_EN
                    if (early_in) begin
                        state_d = S_FIX;
                        acc_d   = early_acc;
                        rem_d   = early_rem;
                    end
`endif
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[2]) begin
                    rem_d = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CNTW'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                res_d     = res_sel;
                out_tag_d = tag_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // A flush drops the operation in flight and keeps the visible result.
        if (flush) begin
            state_d   = S_IDLE;
            done_d    = 1'b0;
            res_d     = res_q;
            out_tag_d = out_tag_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            res_q     <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            res_q     <= res_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign res     = res_q;
    assign out_tag = out_tag_q;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter -- directed and random checks of mdu_iter (XLEN=32, TAGW=5).
// The expected result, tag and latency of each operation are pushed into a
// queue when the operation is driven. They are popped and compared when
// done is observed.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        Rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  in_tag;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic [4:0]  out_tag;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    mdu_iter #(.XLEN(32), .TAGW(5)) dut (
        .clk     (clk),
        .Rst     (Rst),
        .start   (start),
        .flush   (flush),
        .op      (op),
        .a       (a),
        .b       (b),
        .in_tag  (in_tag),
        .busy    (busy),
        .done    (done),
        .res     (res),
        .out_tag (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model in the RISC-V M semantics, using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] av,
                                          input logic [31:0] bv);
        longint sa, sbv, ua, ub, p;
        logic   ovf;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        ua  = longint'({32'd0, av});
        ub  = longint'({32'd0, bv});
        ovf = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
        p   = 0;
        case (o)
            3'd0: begin p = sa * sbv; return p[31:0];  end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (bv == 0) return 32'hFFFF_FFFF;
                if (ovf)     return av;
                p = sa / sbv; return p[31:0];
            end
            3'd5: begin
                if (bv == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (bv == 0) return av;
                if (ovf)     return 32'd0;
                p = sa % sbv; return p[31:0];
            end
            default: begin
                if (bv == 0) return av;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] av,
                                     input logic [31:0] bv);
`ifdef MDU_EARLY_OUT_EN
        if (o[2] && bv == 0) return 2;
        if ((o == 3'd4 || o == 3'd6) && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 2;
        if (!o[2] && (av == 0 || bv == 0)) return 2;
`endif
        return 34;
    endfunction

    // Called at posedge+1. Returns at posedge+1 of the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] t);
        exp_t e;
        int   n;
        int   busy_n;
        e.res = model(o, av, bv);
        e.tag = t;
        e.lat = model_lat(o, av, bv);
        sbq.push_back(e);
        op = o; a = av; b = bv; in_tag = t; start = 1'b1;
        @(posedge clk); #1;                         // E0
        start  = 1'b0;
        n      = 1;
        busy_n = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            n++;
        end
        e = sbq.pop_front();
        check("done_seen",    {63'd0, done}, 64'd1);
        check("res",          {32'd0, res}, {32'd0, e.res});
        check("out_tag",      {59'd0, out_tag}, {59'd0, e.tag});
        check("latency",      64'(n), 64'(e.lat));
        check("busy_cycles",  64'(busy_n), 64'(e.lat - 1));
        check("busy_at_done", {63'd0, busy}, 64'd0);
        $display("[TB] op=%0d a=0x%08h b=0x%08h tag=%0d -> res=0x%08h exp=0x%08h edges=%0d",
                 o, av, bv, t, res, e.res, n);
    endtask

    // One idle edge after a done cycle: the pulse must end and res must hold.
    task automatic post_done_check();
        logic [31:0] r;
        r = res;
        @(posedge clk); #1;
        check("done_single_pulse", {63'd0, done}, 64'd0);
        check("res_held",          {32'd0, res}, {32'd0, r});
    endtask

    logic [31:0] prev_res;
    logic [4:0]  prev_tag;

    initial begin
        Rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = 3'd0; a = '0; b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    {63'd0, busy}, 64'd0);
        check("rst_done",    {63'd0, done}, 64'd0);
        check("rst_res",     {32'd0, res}, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);
        Rst = 1'b0;
        @(posedge clk); #1;

        // Directed operations
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        check("mul_known", {32'd0, res}, 64'hFFFF_FFEB);
        post_done_check();
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        check("mulh_known", {32'd0, res}, 64'h4000_0000);
        run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd2);
        check("mulhsu_known", {32'd0, res}, 64'hC000_0000);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3);
        check("mulhu_known", {32'd0, res}, 64'h4000_0000);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        check("div_known", {32'd0, res}, 64'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        check("rem_known", {32'd0, res}, 64'hFFFF_FFFF);
        run_op(3'd7, 32'd100, 32'd7, 5'd7);
        check("remu_known", {32'd0, res}, 64'd2);
        post_done_check();
        run_op(3'd5, 32'h0000_1234, 32'd0, 5'd8);
        run_op(3'd7, 32'h0000_1234, 32'd0, 5'd9);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd12);   // negative / 0
        run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd13);
        run_op(3'd0, 32'd0, 32'hDEAD_BEEF, 5'd14);   // zero multiply
        run_op(3'd1, 32'hFFFF_FFFF, 32'd0, 5'd15);
        // Back-to-back: second start driven in the done cycle
        run_op(3'd5, 32'hFFFF_FFFF, 32'd3, 5'd16);
        run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd17);
        post_done_check();

        // Flush in the middle of a DIV while a second start is also raised
        prev_res = res;
        prev_tag = out_tag;
        op = 3'd4; a = 32'd1000; b = 32'd3; in_tag = 5'd20; start = 1'b1;
        @(posedge clk); #1;                         // E0
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end    // after E3
        op = 3'd0; a = 32'd5; b = 32'd6; in_tag = 5'd21; start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            check("midop_busy", {63'd0, busy}, 64'd1);
            check("midop_done", {63'd0, done}, 64'd0);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush_busy",    {63'd0, busy}, 64'd0);
        check("flush_done",    {63'd0, done}, 64'd0);
        check("flush_res",     {32'd0, res}, {32'd0, prev_res});
        check("flush_out_tag", {59'd0, out_tag}, {59'd0, prev_tag});
        flush = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("after_flush_busy", {63'd0, busy}, 64'd0);
        check("after_flush_done", {63'd0, done}, 64'd0);
        run_op(3'd4, 32'd1000, 32'd3, 5'd22);

        // Reset in the middle of a MUL
        op = 3'd0; a = 32'd12345; b = 32'd678; in_tag = 5'd23; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        Rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy",    {63'd0, busy}, 64'd0);
        check("midrst_done",    {63'd0, done}, 64'd0);
        check("midrst_res",     {32'd0, res}, 64'd0);
        check("midrst_out_tag", {59'd0, out_tag}, 64'd0);
        Rst = 1'b0;
        @(posedge clk); #1;

        // Start together with flush while idle: start is dropped
        op = 3'd3; a = 32'd9; b = 32'd9; in_tag = 5'd24; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("start_flush_busy", {63'd0, busy}, 64'd0);
        start = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("start_flush_busy2", {63'd0, busy}, 64'd0);
        check("start_flush_done",  {63'd0, done}, 64'd0);

        // Random operations, some with zero or extreme operands
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) rb = 32'd0;
            if (i % 7 == 2) ra = 32'h8000_0000;
            if (i % 4 == 3) rb = 32'($urandom_range(1, 15));
            run_op(ro, ra, rb, 5'(i));
        end
        post_done_check();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
